// File: rtl/gpr_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : gpr_file_mp
//  Brief    : Parametrised multi-port GPR file with two write ports, NRD
//             combinational read ports with write-to-read bypass, a
//             per-register pending scoreboard and a sequential clear sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module gpr_file_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    output logic                ready_o,
    input  logic [1:0]          we_i,
    input  logic [2*AW-1:0]     waddr_i,
    input  logic [2*XLEN-1:0]   wdata_i,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    input  logic                iss_we_i,
    input  logic [AW-1:0]       iss_rd_i,
    output logic [NRD-1:0]      pend_o
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Register 0 is hard-wired, so the sweep runs from 1 up to the last index.
    localparam logic [AW-1:0] c_FIRST_IDX = AW'(1);
    localparam logic [AW-1:0] c_LAST_IDX  = AW'(NREGS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [AW-1:0]    idx_q;
    logic [AW-1:0]    idx_d;
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [XLEN-1:0]  regs_q [NREGS];

    logic             w_live;
    logic             w_issue;
    logic [1:0]       w_commit;
    logic [AW-1:0]    w_waddr [2];
    logic [XLEN-1:0]  w_wdata [2];
    logic [AW-1:0]    w_raddr [NRD];
    logic             w_wr_hit;
    logic             w_iss_hit;

    // Unpack the write buses and decide which writes/issue actually take effect
    always_comb begin
        w_live  = (state_q == ST_READY) && !rst && !clr_i;
        w_issue = w_live && iss_we_i && (iss_rd_i != '0);
        for (int p = 0; p < 2; p++) begin
            w_waddr[p]  = waddr_i[p*AW +: AW];
            w_wdata[p]  = wdata_i[p*XLEN +: XLEN];
            w_commit[p] = w_live && we_i[p] && (w_waddr[p] != '0);
        end
    end

    // Next-state logic: sweep counter, clear request, scoreboard update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        case (state_q)
            ST_CLEAR: begin
                idx_d = idx_q + c_FIRST_IDX;
                if (idx_q == c_LAST_IDX) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    idx_d   = c_FIRST_IDX;
                    pend_d  = '0;
                end else begin
                    for (int p = 0; p < 2; p++) begin
                        if (w_commit[p]) begin
                            pend_d[w_waddr[p]] = 1'b0;
                        end
                    end
                    // A newer producer issued this cycle overrides the retiring one.
                    if (w_issue) begin
                        pend_d[iss_rd_i] = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = c_FIRST_IDX;
            end
        endcase
    end

    // Control state register with synchronous reset into a fresh sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            idx_q   <= c_FIRST_IDX;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    // Storage: zero one entry per cycle while clearing, else commit writes (port 1 last wins)
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                regs_q[idx_q] <= '0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (w_commit[p]) begin
                        regs_q[w_waddr[p]] <= w_wdata[p];
                    end
                end
            end
        end
    end

    // Read ports with same-cycle bypass and bypass-consistent pending flags
    always_comb begin
        rdata_o   = '0;
        pend_o    = '0;
        w_wr_hit  = 1'b0;
        w_iss_hit = 1'b0;
        for (int r = 0; r < NRD; r++) begin
            w_raddr[r] = raddr_i[r*AW +: AW];
            w_wr_hit   = 1'b0;
            w_iss_hit  = 1'b0;
            if (!rst && (state_q == ST_READY) && (w_raddr[r] != '0)) begin
                if (w_commit[1] && (w_waddr[1] == w_raddr[r])) begin
                    rdata_o[r*XLEN +: XLEN] = w_wdata[1];
                end else if (w_commit[0] && (w_waddr[0] == w_raddr[r])) begin
                    rdata_o[r*XLEN +: XLEN] = w_wdata[0];
                end else begin
                    rdata_o[r*XLEN +: XLEN] = regs_q[w_raddr[r]];
                end
                w_wr_hit  = (w_commit[0] && (w_waddr[0] == w_raddr[r])) ||
                            (w_commit[1] && (w_waddr[1] == w_raddr[r]));
                w_iss_hit = w_issue && (iss_rd_i == w_raddr[r]);
                pend_o[r] = (w_wr_hit && !w_iss_hit) ? 1'b0 : pend_q[w_raddr[r]];
            end
        end
    end

    // Ready only while idle in READY and not held in reset
    always_comb begin
        ready_o = (state_q == ST_READY) && !rst;
    end

endmodule
`default_nettype wire
